word_channel_skid_buffer: RTL
=============================

# word_channel_skid_buffer

Two-entry registered skid buffer for a 32-bit word channel with valid/ready handshake. It sits on the return (response) path between a word producer and its consumer, and cuts every combinational path in both directions. Data crosses the block with one-cycle latency at full throughput of one word per cycle.

## Interface
Parameters:
- WIDTH, 32, payload width in bits; must be ≥ 1.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enq_valid  input  1  producer presents a word.
- enq_ready  output  1  block accepts a word this cycle.
- enq_bits  input  WIDTH  producer word.
- deq_valid  output  1  block presents a word.
- deq_ready  input  1  consumer accepts a word this cycle.
- deq_bits  output  WIDTH  word to consumer.
- enq_parity  input  1  even parity of enq_bits. Present only with WORD_SKID_PARITY_EN.
- parity_error  output  1  sticky parity mismatch flag. Present only with WORD_SKID_PARITY_EN.

## Operation
- Storage: output slot OUT drives deq_bits; skid slot SKID holds the overflow word.
- Handshake events:
  - enq fire = enq_valid & enq_ready.
  - deq fire = deq_valid & deq_ready.
- Once deq_valid is asserted, deq_bits remain stable until deq fire.
- Producer-side handshake rule is valid/ready with no retraction requirement imposed by the block.
- State machine states: EMPTY, ONE, TWO.
  - deq_valid = (state != EMPTY).
  - enq_ready = (state != TWO) & !reset.
- EMPTY:
  - enq fire → ONE, OUT ← enq_bits.
- ONE:
  - enq & deq fire → ONE, OUT ← enq_bits.
  - enq fire only → TWO, SKID ← enq_bits.
  - deq fire only → EMPTY.
  - neither → hold.
- TWO:
  - enq_ready = 0, so enq fire is impossible.
  - deq fire → ONE, OUT ← SKID.
  - otherwise hold.
- Word order is strict FIFO. No word is dropped or duplicated.
- Every output is a register or a decode of registered state only. There is no enq→deq and no deq_ready→enq_ready combinational path; reset gating of enq_ready is the sole exception.
- Reset values:
  - state = EMPTY, so deq_valid = 0.
  - enq_ready = 0 while reset is high, and 1 in the first cycle after reset deasserts.
  - OUT = 0, so deq_bits = 0.
  - SKID = 0.
  - parity_error = 0.
- Reset asserted mid-operation discards both stored words in the same edge. Handshakes in that cycle have no effect.

## Timing
- Latency: a word accepted at edge N is visible on deq_valid/deq_bits after edge N.
- Throughput: one word per cycle sustained while deq_ready = 1. Occupancy then stays at ONE.
- When deq_ready drops, one extra word is absorbed into SKID and enq_ready falls one cycle later.
- When deq_ready rises in state TWO, enq_ready rises the cycle after the deq fire.

## Configuration
- Macro: WORD_SKID_PARITY_EN.
- Defined:
  - OUT and SKID each carry an extra parity bit captured from enq_parity.
  - On each deq fire, the block computes even parity of deq_bits and compares it with the stored bit.
  - A mismatch sets parity_error on the next edge. The flag stays set until reset.
  - Data flow is unaffected.
- Undefined:
  - enq_parity and parity_error ports are absent.
  - Storage is WIDTH bits per slot.
  - Behaviour is otherwise identical.

## Test plan
- Reset then idle:
  - Hold reset 3 cycles → deq_valid = 0, deq_bits = 0, enq_ready = 0 during reset.
  - Release reset → enq_ready = 1 on the first post-reset cycle.
- Streaming:
  - Push 0x00000001…0x00000010 with deq_ready held at 1 → outputs appear in order, one per cycle, 1-cycle latency.
  - enq_ready stays 1 throughout.
- Backpressure:
  - With deq_ready = 0, push 0xAAAA5555 then 0x12345678 → state TWO, enq_ready = 0.
  - 0x9 held on enq_bits is not accepted.
  - Raise deq_ready → 0xAAAA5555, 0x12345678, 0x9 emerge in order.
- Simultaneous events:
  - In state ONE holding 0xDEADBEEF, enq 0xCAFEF00D with deq_ready = 1 → 0xDEADBEEF is consumed, OUT = 0xCAFEF00D, state stays ONE.
- Reset mid-operation:
  - In state TWO, assert reset for 1 cycle → deq_valid = 0 next cycle.
  - Neither stored word is ever emitted.
- Parity (WORD_SKID_PARITY_EN defined):
  - Push 0x00000003 with enq_parity = 1 (incorrect) and dequeue → parity_error = 1 next cycle.
  - parity_error stays 1 through subsequent correct words.
  - parity_error clears only on reset.

Source files
------------

// File: rtl/word_channel_skid_buffer.sv
// word_channel_skid_buffer
//
// Two-entry registered skid buffer for a valid/ready word channel. Words pass
// with one cycle of latency at one word per cycle. Every output is a register or
// a decode of registered state, so no combinational path crosses the block in
// either direction. The only exception is enq_ready, which is gated by reset.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   enq_valid     producer presents a word
//   enq_ready     block accepts a word this cycle
//   enq_bits      producer word (WIDTH bits)
//   deq_valid     block presents a word
//   deq_ready     consumer accepts a word this cycle
//   deq_bits      word to consumer (WIDTH bits)
//   enq_parity    even parity of enq_bits      (only with WORD_SKID_PARITY_EN)
//   parity_error  sticky parity mismatch flag  (only with WORD_SKID_PARITY_EN)
//
// Optional feature macro: WORD_SKID_PARITY_EN. When it is defined, each slot
// carries a parity bit, and every dequeued word is checked against that bit.

module word_channel_skid_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits
`ifdef WORD_SKID_PARITY_EN
    ,
    input  logic             enq_parity,
    output logic             parity_error
`endif
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_next;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_skid_next;
    logic             w_enq_fire;
    logic             w_deq_fire;

    // Outputs decode registered state only; reset gating of enq_ready is the
    // single combinational term that comes from outside the block.
    assign deq_valid  = (r_state != StEmpty);
    assign enq_ready  = (r_state != StTwo) & ~reset;
    assign deq_bits   = r_out;
    assign w_enq_fire = enq_valid & enq_ready;
    assign w_deq_fire = deq_valid & deq_ready;

    always_comb begin
        w_state_next = r_state;
        w_out_next   = r_out;
        w_skid_next  = r_skid;
        case (r_state)
            StEmpty: begin
                if (w_enq_fire) begin
                    w_state_next = StOne;
                    w_out_next   = enq_bits;
                end
            end
            StOne: begin
                if (w_enq_fire && w_deq_fire) begin
                    w_out_next = enq_bits;
                end else if (w_enq_fire) begin
                    // Consumer stalled: park the new word behind OUT.
                    w_state_next = StTwo;
                    w_skid_next  = enq_bits;
                end else if (w_deq_fire) begin
                    w_state_next = StEmpty;
                end
            end
            StTwo: begin
                // enq_ready is low here, so only a dequeue can occur.
                if (w_deq_fire) begin
                    w_state_next = StOne;
                    w_out_next   = r_skid;
                end
            end
            default: begin
                w_state_next = StEmpty;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StEmpty;
            r_out   <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            r_skid  <= w_skid_next;
        end
    end

`ifdef WORD_SKID_PARITY_EN
    logic r_out_par;
    logic w_out_par_next;
    logic r_skid_par;
    logic w_skid_par_next;
    logic r_parity_error;
    logic w_parity_error_next;

    // The parity bits follow the same moves as the data slots they belong to.
    always_comb begin
        w_out_par_next  = r_out_par;
        w_skid_par_next = r_skid_par;
        case (r_state)
            StEmpty: begin
                if (w_enq_fire) w_out_par_next = enq_parity;
            end
            StOne: begin
                if (w_enq_fire && w_deq_fire) begin
                    w_out_par_next = enq_parity;
                end else if (w_enq_fire) begin
                    w_skid_par_next = enq_parity;
                end
            end
            StTwo: begin
                if (w_deq_fire) w_out_par_next = r_skid_par;
            end
            default: begin
                w_out_par_next = r_out_par;
            end
        endcase
    end

    // Sticky flag: once set, it stays set until reset.
    assign w_parity_error_next = r_parity_error | (w_deq_fire & ((^r_out) != r_out_par));
    assign parity_error        = r_parity_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_par      <= 1'b0;
            r_skid_par     <= 1'b0;
            r_parity_error <= 1'b0;
        end else begin
            r_out_par      <= w_out_par_next;
            r_skid_par     <= w_skid_par_next;
            r_parity_error <= w_parity_error_next;
        end
    end
`endif

endmodule
